// File: rtl/clock_timebase.sv
// clock_timebase: 1 kHz -> 1 Hz prescaler and 24h BCD time of day.
// Ports: _1kHzIN clk, nCR async reset (low), AdjMinkey/AdjHrkey adjust keys,
//   Hour/Minute/Second BCD time, Tick1Hz tick pulse, Chime hourly chime.
// Option: CHIME_EN enables the hourly chime logic (Chime tied low otherwise).
module clock_timebase #(
  parameter int DIV = 1000
) (
  input  logic       _1kHzIN,
  input  logic       nCR,
  input  logic       AdjMinkey,
  input  logic       AdjHrkey,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic       Tick1Hz,
  output logic       Chime
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    min_sync;
  logic [1:0]    hr_sync;
  logic          adj_m;
  logic          adj_h;
  logic [8:0]    s_inc;
  logic [8:0]    m_inc;
  logic [7:0]    h_inc;
  logic [7:0]    s_nxt;
  logic [7:0]    m_nxt;
  logic [7:0]    h_nxt;

  // {carry, next} for a 00..59 BCD field
  function automatic logic [8:0] inc60(input logic [7:0] v);
    logic [8:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 9'h100;
      else                r = {1'b0, v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)            r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign tick  = (cnt == CW'(DIV - 1));
  assign adj_m = min_sync[1];
  assign adj_h = hr_sync[1];
  assign s_inc = inc60(Second);
  assign m_inc = inc60(Minute);
  assign h_inc = inc24(Hour);

  always_comb begin
    s_nxt = Second;
    m_nxt = Minute;
    h_nxt = Hour;
    unique case (1'b1)
      (!adj_m && !adj_h): begin
        s_nxt = s_inc[7:0];
        if (s_inc[8]) m_nxt = m_inc[7:0];
        if (s_inc[8] && m_inc[8]) h_nxt = h_inc;
      end
      (adj_m && !adj_h): m_nxt = m_inc[7:0];
      (!adj_m && adj_h): h_nxt = h_inc;
      default: begin
        m_nxt = m_inc[7:0];
        h_nxt = h_inc;
      end
    endcase
  end

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) begin
      cnt      <= '0;
      Tick1Hz  <= 1'b0;
      min_sync <= 2'b00;
      hr_sync  <= 2'b00;
      Hour     <= 8'h00;
      Minute   <= 8'h00;
      Second   <= 8'h00;
    end else begin
      cnt      <= tick ? '0 : cnt + CW'(1);
      Tick1Hz  <= tick;
      min_sync <= {min_sync[0], AdjMinkey};
      hr_sync  <= {hr_sync[0], AdjHrkey};
      if (tick) begin
        Hour   <= h_nxt;
        Minute <= m_nxt;
        Second <= s_nxt;
      end
    end
  end

`ifdef CHIME_EN
  // odd seconds 51..59 of minute 59
  function automatic logic chime_win(input logic [7:0] m,
                                     input logic [7:0] s);
    return (m == 8'h59) && (s[7:4] == 4'd5) && s[0];
  endfunction

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) begin
      Chime <= 1'b0;
    end else if (tick) begin
      Chime <= chime_win(m_nxt, s_nxt);
    end
  end
`else
  assign Chime = 1'b0;
`endif

endmodule
